// File: rtl/fifo_burst_writer_if.sv
// Bus bundle for the FIFO burst writer: command, upstream source, FIFO write port and status.
// The master modport is the writer's view; the slave modport is the surrounding logic.
interface fifo_burst_writer_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
);
  logic              cmd_valid_i;
  logic [AWIDTH:0]   cmd_len_i;
  logic              cmd_ready_o;
  logic              cmd_err_o;
  logic              src_valid_i;
  logic [DWIDTH-1:0] src_data_i;
  logic              src_ready_o;
  logic              abort_i;
  logic              wr_full_i;
  logic [AWIDTH-1:0] wr_usedw_i;
  logic              wr_req_o;
  logic [DWIDTH-1:0] wr_data_o;
  logic              busy_o;
  logic              done_o;
  logic              done_aborted_o;
  logic [AWIDTH:0]   done_cnt_o;

  modport master (
    input  cmd_valid_i, cmd_len_i, src_valid_i, src_data_i, abort_i, wr_full_i, wr_usedw_i,
    output cmd_ready_o, cmd_err_o, src_ready_o, wr_req_o, wr_data_o, busy_o, done_o,
    done_aborted_o, done_cnt_o
  );

  modport slave (
    output cmd_valid_i, cmd_len_i, src_valid_i, src_data_i, abort_i, wr_full_i, wr_usedw_i,
    input  cmd_ready_o, cmd_err_o, src_ready_o, wr_req_o, wr_data_o, busy_o, done_o,
    done_aborted_o, done_cnt_o
  );
endinterface

// File: rtl/fifo_burst_writer.sv
// Write-port master for the dual-clock FIFO: reserves space for a whole burst up front,
// then streams the burst from a valid/ready source into registered wr_req/wr_data.
module fifo_burst_writer #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input logic                 wr_clk_i,
  input logic                 aclr_i,
  fifo_burst_writer_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_CHECK  = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [AWIDTH:0] CAP_C  = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] ONE_C  = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [AWIDTH:0] ZERO_C = {(AWIDTH+1){1'b0}};

  state_t            state_r, state_nxt_s;
  logic [AWIDTH:0]   len_r, len_nxt_s, cnt_r, cnt_nxt_s, free_s, done_cnt_r;
  logic              accept_s, src_ready_s, cmd_err_nxt_s, abort_hit_s, enter_done_s;
  logic              cmd_err_r, wr_req_r, done_r, done_aborted_r;
  logic [DWIDTH-1:0] wr_data_r;

  // A full FIFO reports usedw=0, so full must force free space to zero.
  assign free_s       = bus.wr_full_i ? ZERO_C : (CAP_C - {1'b0, bus.wr_usedw_i});
  assign enter_done_s = (state_nxt_s == S_DONE) && (state_r != S_DONE);

  // State register.
  always_ff @(posedge wr_clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, source handshake and counter update.
  always_comb begin
    state_nxt_s   = state_r;
    len_nxt_s     = len_r;
    cnt_nxt_s     = cnt_r;
    accept_s      = 1'b0;
    src_ready_s   = 1'b0;
    cmd_err_nxt_s = 1'b0;
    abort_hit_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.cmd_valid_i) begin
          len_nxt_s = bus.cmd_len_i;
          if ((bus.cmd_len_i != ZERO_C) && (bus.cmd_len_i <= CAP_C)) begin
            state_nxt_s = S_SETTLE;
          end else begin
            cmd_err_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (bus.abort_i) begin
          abort_hit_s = 1'b1;
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bus.abort_i) begin
          abort_hit_s = 1'b1;
          state_nxt_s = S_DONE;
        end else if (free_s >= len_r) begin
          state_nxt_s = S_WRITE;
        end else begin
          state_nxt_s = S_CHECK;
        end
      end
      S_WRITE: begin
        if (bus.abort_i) begin
          abort_hit_s = 1'b1;
          state_nxt_s = S_DONE;
        end else begin
          src_ready_s = 1'b1;
          if (bus.src_valid_i) begin
            accept_s  = 1'b1;
            cnt_nxt_s = cnt_r + ONE_C;
            if ((cnt_r + ONE_C) == len_r) begin
              state_nxt_s = S_DONE;
            end else begin
              state_nxt_s = S_WRITE;
            end
          end else begin
            state_nxt_s = S_WRITE;
          end
        end
      end
      S_DONE: begin
        cnt_nxt_s   = ZERO_C;
        state_nxt_s = S_IDLE;
      end
      default: begin
        cnt_nxt_s   = ZERO_C;
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Datapath and registered status outputs.
  always_ff @(posedge wr_clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      len_r          <= ZERO_C;
      cnt_r          <= ZERO_C;
      cmd_err_r      <= 1'b0;
      wr_req_r       <= 1'b0;
      wr_data_r      <= {DWIDTH{1'b0}};
      done_r         <= 1'b0;
      done_aborted_r <= 1'b0;
      done_cnt_r     <= ZERO_C;
    end else begin
      len_r          <= len_nxt_s;
      cnt_r          <= cnt_nxt_s;
      cmd_err_r      <= cmd_err_nxt_s;
      wr_req_r       <= accept_s;
      done_r         <= enter_done_s;
      done_aborted_r <= enter_done_s & abort_hit_s;
      if (accept_s) begin
        wr_data_r <= bus.src_data_i;
      end else begin
        wr_data_r <= wr_data_r;
      end
      if (enter_done_s) begin
        done_cnt_r <= cnt_nxt_s;
      end else begin
        done_cnt_r <= done_cnt_r;
      end
    end
  end

  assign bus.cmd_ready_o    = (state_r == S_IDLE);
  assign bus.src_ready_o    = src_ready_s;
  assign bus.busy_o         = (state_r != S_IDLE);
  assign bus.cmd_err_o      = cmd_err_r;
  assign bus.wr_req_o       = wr_req_r;
  assign bus.wr_data_o      = wr_data_r;
  assign bus.done_o         = done_r;
  assign bus.done_aborted_o = done_aborted_r;
  assign bus.done_cnt_o     = done_cnt_r;
endmodule
